// File: rtl/robsmult_n.sv
// Iterative Robertson shift-add multiplier: one partial-product step per clock,
// per-operation signed/unsigned mode, start/busy/done handshake.
module robsmult_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               mode_q, mode_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH:0]     y_ext;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic               last;

  always_comb begin
    y_ext  = {mode_q & y_q[WIDTH-1], y_q};
    addend = x_q[0] ? y_ext : '0;
    last   = (count_q == '0);
    // The multiplier sign bit carries negative weight, so the final step subtracts.
    sum    = (last && mode_q) ? (a_q - addend) : (a_q + addend);
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    x_d       = x_q;
    y_d       = y_q;
    mode_d    = mode_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          y_d     = multiplicand;
          x_d     = multiplier;
          mode_d  = signed_mode;
          a_d     = '0;
          count_d = CntW'(WIDTH - 1);
        end
      end
      StRun: begin
        // Unsigned: sum[WIDTH] is a carry that becomes a[WIDTH-1]; A's top bit stays zero.
        a_d     = {mode_q & sum[WIDTH], sum[WIDTH:1]};
        x_d     = {sum[0], x_q[WIDTH-1:1]};
        count_d = count_q - 1'b1;
        if (last) begin
          state_d   = StDone;
          product_d = {a_d[WIDTH-1:0], x_d};
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      mode_q    <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      x_q       <= x_d;
      y_q       <= y_d;
      mode_q    <= mode_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule

// File: tb/tb_robsmult_n.sv
// Bench for robsmult_n: directed WIDTH=8 vector table, handshake/reset sequences,
// and parallel width sweeps (2, 5 exhaustive; 16, 32 random) against a reference product.
module tb_robsmult_n;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [7:0]  multiplier;
  logic [7:0]  multiplicand;
  logic        busy;
  logic        done;
  logic [15:0] product;

  logic        sw_reset;
  bit          sw_ready = 1'b0;

  robsmult_n #(.WIDTH(8)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Width sweeps run concurrently with the directed tests on their own instances.
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int W = (g == 0) ? 2 : (g == 1) ? 5 : (g == 2) ? 16 : 32;
    localparam bit Exh = (W <= 5);

    logic             st;
    logic             md;
    logic [W-1:0]     xa;
    logic [W-1:0]     ya;
    logic             bz;
    logic             dn;
    logic [2*W-1:0]   pr;
    logic [2*W-1:0]   exp_p;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     minv;
    logic             m;
    int               lat;
    int               n;
    bit               fin = 1'b0;

    robsmult_n #(.WIDTH(W)) u_sw (
      .clk          (clk),
      .reset        (sw_reset),
      .start        (st),
      .signed_mode  (md),
      .multiplier   (xa),
      .multiplicand (ya),
      .busy         (bz),
      .done         (dn),
      .product      (pr)
    );

    initial begin
      st = 1'b0;
      md = 1'b0;
      xa = '0;
      ya = '0;
      minv = '0;
      minv[W-1] = 1'b1;
      wait (sw_ready);
      @(posedge clk);
      #1;
      n = Exh ? (2 << (2 * W)) : 300;
      for (int i = 0; i < n; i++) begin
        if (Exh) begin
          a = W'(i);
          b = W'(i >> W);
          m = 1'((i >> (2 * W)) & 1);
        end else if (i < 8) begin
          a = i[0] ? minv : '1;
          b = i[1] ? minv : '1;
          m = i[2];
        end else begin
          a = W'({$urandom, $urandom});
          b = W'({$urandom, $urandom});
          m = 1'($urandom);
        end
        if (m) exp_p = $signed(a) * $signed(b);
        else   exp_p = a * b;
        st = 1'b1;
        md = m;
        xa = a;
        ya = b;
        @(posedge clk);
        #1;
        st = 1'b0;
        md = ~m;
        xa = ~a;
        ya = ~b;
        lat = 0;
        while (!dn && lat < W + 4) begin
          @(posedge clk);
          #1;
          lat++;
        end
        chk($sformatf("sweep_w%0d_latency", W), 64'(lat), 64'(W));
        chk($sformatf("sweep_w%0d_product", W), 64'(pr), 64'(exp_p));
        @(posedge clk);
        #1;
      end
      fin = 1'b1;
    end
  end

  typedef struct {
    logic        m;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  // Returns product at done, cycles from accepting edge to done, and whether product
  // held its old value with busy high through RUN, and done lasted exactly one cycle.
  task automatic run_op(input logic m, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] hold_val, output logic [15:0] p,
                        output int lat, output bit ok);
    start = 1'b1;
    signed_mode = m;
    multiplier = a;
    multiplicand = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    multiplier = 8'h5A;
    multiplicand = 8'hC3;
    signed_mode = ~m;
    lat = 0;
    ok = 1'b1;
    while (!done && lat < 12) begin
      if (product !== hold_val || !busy) ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    p = product;
    if (!busy) ok = 1'b0;
    @(posedge clk);
    #1;
    if (busy || done) ok = 1'b0;
  endtask

  initial begin
    logic [15:0] p;
    logic [15:0] prev;
    logic [15:0] got;
    logic [15:0] p1;
    logic [15:0] p2;
    logic [15:0] p17;
    int          lat;
    int          nd;
    int          c1;
    int          c2;
    int          t;
    bit          ok;

    vecs[0]  = '{1'b1, 8'h07, 8'h03, 16'h0015};
    vecs[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[2]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[3]  = '{1'b1, 8'h7F, 8'hFF, 16'hFF81};
    vecs[4]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[5]  = '{1'b0, 8'h80, 8'h02, 16'h0100};
    vecs[6]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[7]  = '{1'b1, 8'h80, 8'h02, 16'hFF00};
    vecs[8]  = '{1'b0, 8'h05, 8'h05, 16'h0019};
    vecs[9]  = '{1'b0, 8'h00, 8'hAB, 16'h0000};
    vecs[10] = '{1'b1, 8'h01, 8'h80, 16'hFF80};
    vecs[11] = '{1'b0, 8'h80, 8'h80, 16'h4000};

    reset = 1'b1;
    sw_reset = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    multiplier = '0;
    multiplicand = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_product", 64'(product), 64'(0));
    reset = 1'b0;
    sw_reset = 1'b0;
    sw_ready = 1'b1;

    prev = 16'h0000;
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].m, vecs[i].x, vecs[i].y, prev, p, lat, ok);
      chk($sformatf("vec%0d_product", i), 64'(p), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(8));
      chk($sformatf("vec%0d_hold_busy", i), 64'(ok), 64'(1));
      prev = vecs[i].exp;
    end

    // start pulses during RUN and in the DONE cycle must all be ignored.
    start = 1'b1;
    signed_mode = 1'b1;
    multiplier = 8'h07;
    multiplicand = 8'h03;
    @(posedge clk);
    #1;
    multiplier = 8'h09;
    multiplicand = 8'h09;
    nd = 0;
    c1 = 0;
    got = '0;
    for (int c = 1; c <= 14; c++) begin
      start = (c == 1 || c == 5 || c == 9);
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        c1 = c;
        got = product;
      end
    end
    start = 1'b0;
    chk("ignore_done_count", 64'(nd), 64'(1));
    chk("ignore_done_cycle", 64'(c1), 64'(8));
    chk("ignore_product", 64'(got), 64'(16'h0015));
    chk("ignore_idle_after", 64'(busy), 64'(0));

    // start held high: back-to-back ops 10 cycles apart.
    start = 1'b1;
    signed_mode = 1'b0;
    multiplier = 8'h0C;
    multiplicand = 8'h0B;
    @(posedge clk);
    #1;
    multiplier = 8'h10;
    multiplicand = 8'h20;
    nd = 0;
    c1 = 0;
    c2 = 0;
    p1 = '0;
    p2 = '0;
    p17 = '0;
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk);
      #1;
      if (c == 17) p17 = product;
      if (done) begin
        if (nd == 0) begin
          c1 = c;
          p1 = product;
        end else begin
          c2 = c;
          p2 = product;
        end
        nd++;
      end
      if (c == 18) start = 1'b0;
    end
    start = 1'b0;
    chk("b2b_done_count", 64'(nd), 64'(2));
    chk("b2b_first_cycle", 64'(c1), 64'(8));
    chk("b2b_first_product", 64'(p1), 64'(16'h0084));
    chk("b2b_hold_product", 64'(p17), 64'(16'h0084));
    chk("b2b_second_cycle", 64'(c2), 64'(18));
    chk("b2b_second_product", 64'(p2), 64'(16'h0200));
    chk("b2b_idle_after", 64'(busy), 64'(0));

    // Reset in the 4th RUN cycle aborts with no done.
    start = 1'b1;
    signed_mode = 1'b0;
    multiplier = 8'h09;
    multiplicand = 8'h09;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_product", 64'(product), 64'(0));
    nd = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'(0));
    run_op(1'b0, 8'h05, 8'h05, 16'h0000, p, lat, ok);
    chk("after_abort_product", 64'(p), 64'(16'h0019));
    chk("after_abort_latency", 64'(lat), 64'(8));
    chk("after_abort_hold_busy", 64'(ok), 64'(1));

    t = 0;
    while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin && g_sw[3].fin) && t < 40000) begin
      @(posedge clk);
      t++;
    end
    chk("sweep_completed", 64'(t < 40000), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
